// File: rtl/spi_master_ctrl.sv
// SPI master (mode 0) for the mtc0/mfc0 SPI ops. It shifts a register-file
// word out MSB first while clocking a word in. The CPU is stalled from the
// accepting IDLE cycle through SHIFT, and released for one DONE cycle.

`ifndef W_SPI_CTRL
`define W_SPI_CTRL 2
`endif
`ifndef SPI_NOP
`define SPI_NOP 2'd0
`endif
`ifndef MOSI
`define MOSI 2'd1
`endif
`ifndef MISO
`define MISO 2'd2
`endif
`ifndef W_CPU
`define W_CPU 32
`endif

module spi_master_ctrl #(
  parameter int W_DATA  = `W_CPU,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`W_SPI_CTRL-1:0] spi_ctrl,
  input  logic [W_DATA-1:0]      wdata,
  output logic [W_DATA-1:0]      rdata,
  output logic                   stall,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic                   cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(W_DATA + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [W_DATA-1:0]  tx_sh;   // bits still to send, next one at MSB
  logic [W_DATA-1:0]  rx_sh;
  logic               is_mosi, req, div_tc, last_fall;

  // Encodings other than MOSI/MISO fall through as NOP.
  assign is_mosi   = (spi_ctrl == `MOSI);
  assign req       = is_mosi || (spi_ctrl == `MISO);
  assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_fall = div_tc && sclk && (bit_cnt == BIT_W'(W_DATA));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and stall; DONE ignores spi_ctrl since the instruction is still present.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = SHIFT;
      end
      SHIFT: begin
        stall = 1'b1;
        if (last_fall) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus datapath: divider, sclk generation, shift registers and the rdata latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rdata   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // MISO transmits zeros; first bit goes out before the first rise.
            tx_sh   <= is_mosi ? {wdata[W_DATA-2:0], 1'b0} : '0;
            mosi    <= is_mosi & wdata[W_DATA-1];
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              // Rising edge: sample the slave.
              rx_sh   <= {rx_sh[W_DATA-2:0], miso};
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else if (bit_cnt != BIT_W'(W_DATA)) begin
              // Falling edge: present the next bit.
              mosi  <= tx_sh[W_DATA-1];
              tx_sh <= {tx_sh[W_DATA-2:0], 1'b0};
            end else begin
              // Final falling edge closes the frame.
              rdata <= rx_sh;
              cs_n  <= 1'b1;
              mosi  <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl (W_DATA=32, CLK_DIV=4). A timeline model predicts
// every output from the cycle offset inside a frame, and it drives miso itself.
// Directed frames pin the model with literal values.

`ifndef W_SPI_CTRL
`define W_SPI_CTRL 2
`endif
`ifndef SPI_NOP
`define SPI_NOP 2'd0
`endif
`ifndef MOSI
`define MOSI 2'd1
`endif
`ifndef MISO
`define MISO 2'd2
`endif
`ifndef W_CPU
`define W_CPU 32
`endif

module tb_spi_master_ctrl;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int SH = 2 * W * D;   // SHIFT length in cycles
  localparam int DN = SH + 1;      // offset of the DONE cycle

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [`W_SPI_CTRL-1:0] spi_ctrl = `SPI_NOP;
  logic [W-1:0]           wdata = '0;
  logic [W-1:0]           rdata;
  logic                   stall, busy, sclk, mosi, cs_n;
  logic                   miso = 1'b0;

  int n_checks = 0;
  int n_errs   = 0;

  spi_master_ctrl #(.W_DATA(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .spi_ctrl(spi_ctrl), .wdata(wdata), .rdata(rdata),
    .stall(stall), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_req(input logic [`W_SPI_CTRL-1:0] op);
    return (op == `MOSI) || (op == `MISO);
  endfunction

  // Model state: m_k = 0 idle, 1..SH shifting, DN done.
  int          m_k = 0;
  logic [W-1:0] m_tx = '0, m_slave = '0, m_rexp = '0;
  logic [W-1:0] slave_next = '0;

  // Compare process: check this cycle's outputs, then advance across the next posedge.
  always @(negedge clk) begin : cmp
    int half;
    logic e_stall, e_busy, e_cs, e_sclk, e_mosi;
    if (rst) begin
      m_k    = 0;
      m_rexp = '0;
    end
    e_stall = 1'b0; e_busy = 1'b0; e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
    if (m_k == 0) begin
      e_stall = is_req(spi_ctrl);
    end else if (m_k <= SH) begin
      half    = (m_k - 1) / D;
      e_stall = 1'b1;
      e_busy  = 1'b1;
      e_cs    = 1'b0;
      e_sclk  = half[0];
      e_mosi  = m_tx[W - 1 - half / 2];
    end else begin
      e_busy = 1'b1;
    end
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("busy",  {31'd0, busy},  {31'd0, e_busy});
    chk("cs_n",  {31'd0, cs_n},  {31'd0, e_cs});
    chk("sclk",  {31'd0, sclk},  {31'd0, e_sclk});
    chk("mosi",  {31'd0, mosi},  {31'd0, e_mosi});
    chk("rdata", rdata, m_rexp);
    if (!rst) begin
      if (m_k == 0) begin
        if (is_req(spi_ctrl)) begin
          m_tx    = (spi_ctrl == `MOSI) ? wdata : '0;
          m_slave = slave_next;
          m_k     = 1;
        end
      end else if (m_k < SH) begin
        m_k++;
      end else if (m_k == SH) begin
        m_k    = DN;
        m_rexp = m_slave;
      end else begin
        m_k = 0;
      end
    end
    // Slave holds bit i for both halves of sclk period i.
    if (m_k >= 1 && m_k <= SH) miso = m_slave[W - 1 - ((m_k - 1) / D) / 2];
    else                       miso = 1'($urandom);
  end

  // One frame: returns mosi bits seen at sclk rises, stalled and cs_n-high cycle counts, rdata in DONE.
  task automatic do_xfer(input logic [1:0] op, input logic [W-1:0] wd, input logic [W-1:0] sw,
                         input bit hold, output logic [W-1:0] bits, output int nst,
                         output int nch, output logic [W-1:0] rd);
    int cyc;
    bit ok, prev;
    cyc = 0; ok = 0; prev = 0; bits = '0; nst = 0; nch = 0; rd = '0;
    slave_next = sw;
    @(posedge clk); #2;
    spi_ctrl = op;
    wdata    = wd;
    while (cyc < 2000 && !ok) begin
      @(negedge clk);
      cyc++;
      if (stall) nst++;
      if (cs_n)  nch++;
      if (sclk && !prev) bits = {bits[W-2:0], mosi};
      prev = sclk;
      if (busy && !stall) begin
        ok = 1;
        rd = rdata;
      end else if (cyc == 1) begin
        @(posedge clk); #2;
        wdata = $urandom;   // must not leak into the frame
      end
    end
    chk("xfer_done", {31'd0, ok}, 32'd1);
    if (!hold) begin
      @(posedge clk); #2;
      spi_ctrl = `SPI_NOP;
    end
  endtask

  initial begin : stim
    logic [W-1:0] bits, rd;
    int nst, nch, rises, cyc, cnt;
    bit prev;

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // NOP and an undefined encoding: nothing may happen.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      spi_ctrl = (i < 50) ? `SPI_NOP : 2'd3;
      wdata    = $urandom;
      @(negedge clk);
      if (stall || busy || !cs_n || sclk) cnt++;
    end
    chk("nop_idle", cnt, 0);
    @(posedge clk); #2 spi_ctrl = `SPI_NOP;

    // Async reset after the 10th sclk rise.
    slave_next = 32'hCAFEF00D;
    @(posedge clk); #2;
    spi_ctrl = `MOSI;
    wdata    = 32'hFFFF_FFFF;
    rises = 0; cyc = 0; prev = 0;
    while (rises < 10 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    chk("rst_reach", rises, 10);
    #3 rst = 1'b1;
    #1;
    chk("rst_cs_n",  {31'd0, cs_n}, 32'd1);
    chk("rst_sclk",  {31'd0, sclk}, 32'd0);
    chk("rst_mosi",  {31'd0, mosi}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    spi_ctrl = `SPI_NOP;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Frame after reset completes normally.
    do_xfer(`MISO, 32'h0, 32'h0BADF00D, 0, bits, nst, nch, rd);
    chk("post_rst_rdata", rd, 32'h0BADF00D);

    // MOSI pattern, MSB first.
    do_xfer(`MOSI, 32'hA5A50F0F, 32'h13572468, 0, bits, nst, nch, rd);
    chk("mosi_bits",  bits, 32'hA5A50F0F);
    chk("mosi_stall", nst, 257);
    chk("mosi_csh",   nch, 2);
    chk("mosi_rdata", rd, 32'h13572468);

    // MISO from slave.
    do_xfer(`MISO, 32'hFFFFFFFF, 32'hDEADBEEF, 0, bits, nst, nch, rd);
    chk("miso_rdata", rd, 32'hDEADBEEF);
    chk("miso_mosi0", bits, 32'h0);
    chk("miso_stall", nst, 257);

    // Back-to-back: MOSI then MISO with no gap on the request side.
    do_xfer(`MOSI, 32'h00000001, 32'h80000001, 1, bits, nst, nch, rd);
    chk("b2b1_bits",  bits, 32'h00000001);
    chk("b2b1_rdata", rd, 32'h80000001);
    do_xfer(`MISO, 32'h0, 32'h12345678, 0, bits, nst, nch, rd);
    chk("b2b2_csh",   nch, 2);
    chk("b2b2_rdata", rd, 32'h12345678);

    // MOSI held through DONE: the IDLE cycle after DONE accepts again.
    do_xfer(`MOSI, 32'h5555AAAA, 32'h0, 1, bits, nst, nch, rd);
    @(negedge clk);
    chk("hold_idle_busy",  {31'd0, busy},  32'd0);
    chk("hold_idle_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("hold_restart", {31'd0, busy & ~cs_n}, 32'd1);
    @(posedge clk); #2 spi_ctrl = `SPI_NOP;
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_finish", {31'd0, busy}, 32'd0);

    // Random ops, data and slave words with occasional async resets.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #2;
      rst        = 1'b0;
      spi_ctrl   = 2'($urandom_range(0, 3));
      wdata      = $urandom;
      slave_next = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        #1 rst = 1'b1;
      end
    end
    @(posedge clk); #2;
    rst      = 1'b0;
    spi_ctrl = `SPI_NOP;
    repeat (300) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
